// File: rtl/drive_pkg.sv
// Shared definitions for the drive sequencer.
//   state_e     : FSM state encoding, also the HEX display code on oState
//   DIR_*       : H-bridge IN-pair codes (IN1,IN2)
//   ms_divisor  : clock cycles per 1 ms tick, never less than 1
package drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_BRAKE = 3'd2,
        ST_REV   = 3'd3,
        ST_TURN  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_BRK   = 2'b11;
    localparam logic [1:0] DIR_COAST = 2'b00;

    localparam logic [7:0] DUTY_BRAKE = 8'd255;
    localparam logic [7:0] RAMP_STEP  = 8'd8;

    function automatic int unsigned ms_divisor(input int unsigned clk_hz);
        return (clk_hz / 1000 > 0) ? clk_hz / 1000 : 1;
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// Soft-start ramp generator (used only when SOFT_START_EN is defined).
//   iCLK, iRST : clock, asynchronous active-high reset
//   iRestart   : forces the level back to 0 (state entry)
//   iTick      : 1 ms tick; each tick raises the level by RAMP_STEP
//   iTarget    : level the ramp saturates at (live operator duty)
//   oLevel     : current ramp level, never above iTarget once settled
module duty_ramp
    import drive_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iRestart,
    input  logic       iTick,
    input  logic [7:0] iTarget,
    output logic [7:0] oLevel
);

    logic [7:0] level_q, level_d;
    logic [8:0] sum;

    always_comb begin
        sum     = {1'b0, level_q} + {1'b0, RAMP_STEP};
        level_d = level_q;
        if (iRestart) begin
            level_d = '0;
        end else if (iTick) begin
            level_d = (sum >= {1'b0, iTarget}) ? iTarget : sum[7:0];
        end else if (level_q > iTarget) begin
            // operator lowered the duty mid-ramp: follow it down at once
            level_d = iTarget;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) level_q <= '0;
        else      level_q <= level_d;
    end

    assign oLevel = level_q;

endmodule

// File: rtl/drive_sequencer.sv
// Obstacle-avoidance sequencer between the ultrasonic ranger and two motor
// PWM drivers. Sequences IDLE/FWD/BRAKE/REV/TURN/FAULT from distance samples.
// Optional feature macro: SOFT_START_EN (duty ramps up on FWD/REV/TURN entry).
// Ports:
//   iCLK, iRST        clock, asynchronous active-high reset
//   iEnable           run request (level); low forces IDLE
//   iDistance[15:0]   distance in cm, 0 = no echo
//   iDistValid        one-cycle strobe qualifying iDistance
//   iDuty[7:0]        operator duty, used live every cycle
//   oDutyL/oDutyR     per-motor duty
//   oDirL/oDirR       H-bridge IN pairs (10 fwd, 01 rev, 11 brake, 00 coast)
//   oState[2:0]       state code for display / debug
//   oObstacle         high while the near count is saturated
// All outputs are registered from the state register (one cycle behind it).
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int STOP_CM    = 20,
    parameter int CLEAR_CM   = 30,
    parameter int CONFIRM_N  = 3,
    parameter int BRAKE_MS   = 100,
    parameter int REVERSE_MS = 400,
    parameter int TURN_MS    = 300,
    parameter int TIMEOUT_MS = 200,
    parameter int MAX_RETRY  = 3
)(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic [15:0] iDistance,
    input  logic        iDistValid,
    input  logic [7:0]  iDuty,
    output logic [7:0]  oDutyL,
    output logic [7:0]  oDutyR,
    output logic [1:0]  oDirL,
    output logic [1:0]  oDirR,
    output logic [2:0]  oState,
    output logic        oObstacle
);

    localparam int unsigned DIV = ms_divisor(CLK_HZ);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    localparam logic [15:0] BRAKE_LAST   = 16'(BRAKE_MS - 1);
    localparam logic [15:0] REV_LAST     = 16'(REVERSE_MS - 1);
    localparam logic [15:0] TURN_LAST    = 16'(TURN_MS - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);
    localparam logic [7:0]  CONF         = 8'(CONFIRM_N);
    localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRY);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [15:0]   timer_q, timer_d;
    logic [15:0]   last_q, last_d;
    logic [7:0]    near_q, near_d;
    logic [7:0]    retry_q, retry_d;

    logic [7:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic [1:0] dir_l_q, dir_l_d, dir_r_q, dir_r_d;
    logic [2:0] state_out_q, state_out_d;
    logic       obstacle_q, obstacle_d;
    logic [7:0] run_duty_l, run_duty_r;

`ifdef SOFT_START_EN
    logic ramp_restart;
    assign ramp_restart = (state_d != state_q);

    duty_ramp u_ramp_l (
        .iCLK(iCLK), .iRST(iRST), .iRestart(ramp_restart),
        .iTick(tick), .iTarget(iDuty), .oLevel(run_duty_l)
    );
    duty_ramp u_ramp_r (
        .iCLK(iCLK), .iRST(iRST), .iRestart(ramp_restart),
        .iTick(tick), .iTarget(iDuty), .oLevel(run_duty_r)
    );
`else
    assign run_duty_l = iDuty;
    assign run_duty_r = iDuty;
`endif

    // Free-running 1 ms prescaler.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Next-state logic. Sample bookkeeping is computed first so that a timer
    // expiry in the same cycle decides on the updated counters.
    always_comb begin
        state_d = state_q;
        timer_d = tick ? timer_q + 1'b1 : timer_q;
        last_d  = last_q;
        near_d  = near_q;
        retry_d = retry_q;

        if (iDistValid && iDistance != 16'd0) begin
            last_d = iDistance;
            if (iDistance < 16'(STOP_CM)) begin
                if (near_q < CONF) near_d = near_q + 1'b1;
            end else begin
                near_d = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                near_d  = '0;
                last_d  = '0;
                retry_d = '0;
                if (iEnable) state_d = ST_FWD;
            end
            ST_FWD: begin
                // any strobe, including a no-echo 0, restarts the timeout
                if (iDistValid) timer_d = '0;
                if (near_d >= CONF)
                    state_d = ST_BRAKE;
                else if (!iDistValid && tick && timer_q == TIMEOUT_LAST)
                    state_d = ST_BRAKE;
            end
            ST_BRAKE: if (tick && timer_q == BRAKE_LAST) state_d = ST_REV;
            ST_REV:   if (tick && timer_q == REV_LAST)   state_d = ST_TURN;
            ST_TURN: begin
                if (tick && timer_q == TURN_LAST) begin
                    if (last_d >= 16'(CLEAR_CM)) begin
                        state_d = ST_FWD;
                        retry_d = '0;
                        near_d  = '0;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d >= RETRY_MAX) ? ST_FAULT : ST_BRAKE;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        if (!iEnable) state_d = ST_IDLE;
        if (state_d != state_q) timer_d = '0;
    end

    // Output decode from the current state; registered below.
    always_comb begin
        duty_l_d    = '0;
        duty_r_d    = '0;
        dir_l_d     = DIR_COAST;
        dir_r_d     = DIR_COAST;
        state_out_d = state_q;
        obstacle_d  = (near_q >= CONF);
        case (state_q)
            ST_FWD: begin
                dir_l_d = DIR_FWD;  dir_r_d = DIR_FWD;
                duty_l_d = run_duty_l; duty_r_d = run_duty_r;
            end
            ST_BRAKE: begin
                dir_l_d = DIR_BRK;  dir_r_d = DIR_BRK;
                duty_l_d = DUTY_BRAKE; duty_r_d = DUTY_BRAKE;
            end
            ST_REV: begin
                dir_l_d = DIR_REV;  dir_r_d = DIR_REV;
                duty_l_d = run_duty_l; duty_r_d = run_duty_r;
            end
            ST_TURN: begin
                dir_l_d = DIR_FWD;  dir_r_d = DIR_REV;
                duty_l_d = run_duty_l; duty_r_d = run_duty_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            timer_q     <= '0;
            last_q      <= '0;
            near_q      <= '0;
            retry_q     <= '0;
            duty_l_q    <= '0;
            duty_r_q    <= '0;
            dir_l_q     <= DIR_COAST;
            dir_r_q     <= DIR_COAST;
            state_out_q <= '0;
            obstacle_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            timer_q     <= timer_d;
            last_q      <= last_d;
            near_q      <= near_d;
            retry_q     <= retry_d;
            duty_l_q    <= duty_l_d;
            duty_r_q    <= duty_r_d;
            dir_l_q     <= dir_l_d;
            dir_r_q     <= dir_r_d;
            state_out_q <= state_out_d;
            obstacle_q  <= obstacle_d;
        end
    end

    assign oDutyL    = duty_l_q;
    assign oDutyR    = duty_r_q;
    assign oDirL     = dir_l_q;
    assign oDirR     = dir_r_q;
    assign oState    = state_out_q;
    assign oObstacle = obstacle_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed testbench for drive_sequencer with CLK_HZ=1000 (one tick per cycle).
module tb_drive_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iEnable = 1'b0;
    logic [15:0] iDistance = '0;
    logic        iDistValid = 1'b0;
    logic [7:0]  iDuty = '0;
    logic [7:0]  oDutyL, oDutyR;
    logic [1:0]  oDirL, oDirR;
    logic [2:0]  oState;
    logic        oObstacle;

    int checks = 0;
    int errors = 0;

    drive_sequencer #(.CLK_HZ(1000)) dut (
        .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable),
        .iDistance(iDistance), .iDistValid(iDistValid), .iDuty(iDuty),
        .oDutyL(oDutyL), .oDutyR(oDutyR), .oDirL(oDirL), .oDirR(oDirR),
        .oState(oState), .oObstacle(oObstacle)
    );

    // clock / reset
    always #5 iCLK = ~iCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iEnable = 1'b0; iDistValid = 1'b0; iDistance = '0;
        iRST = 1'b1;
        step(2);
        iRST = 1'b0;
        step(1);
    endtask

    task automatic sample(input logic [15:0] d);
        iDistValid = 1'b1;
        iDistance  = d;
        step(1);
        iDistValid = 1'b0;
    endtask

    // enable from IDLE; returns once oState shows FWD
    task automatic enter_fwd();
        iEnable = 1'b1;
        step(2);
    endtask

    // count cycles oState stays at s (bounded), optionally strobing a sample
    task automatic measure(input string tag, input logic [2:0] s, input int exp_len,
                           input int inj_at, input logic [15:0] inj_val);
        int cnt;
        cnt = 0;
        while (oState == s && cnt < 1000) begin
            if (cnt == inj_at) begin
                iDistValid = 1'b1;
                iDistance  = inj_val;
            end
            step(1);
            iDistValid = 1'b0;
            cnt++;
        end
        check_eq(tag, cnt, exp_len);
    endtask

    task automatic trigger_brake();
        sample(16'd50);
        sample(16'd19);
        sample(16'd19);
        sample(16'd19);
        check_eq("still_fwd_at_trigger", oState, 3'd1);
        step(1);
        check_eq("brake_state", oState, 3'd2);
        check_eq("brake_dirl", oDirL, 2'b11);
        check_eq("brake_dirr", oDirR, 2'b11);
        check_eq("brake_duty", oDutyL, 8'd255);
        check_eq("obstacle_set", oObstacle, 1'b1);
    endtask

    initial begin
        iDuty = 8'd200;
        do_reset();
        check_eq("rst_state", oState, 3'd0);
        check_eq("rst_dutyl", oDutyL, 8'd0);
        check_eq("rst_dutyr", oDutyR, 8'd0);
        check_eq("rst_dirl", oDirL, 2'b00);
        check_eq("rst_dirr", oDirR, 2'b00);
        check_eq("rst_obst", oObstacle, 1'b0);

        // ---- trigger, BRAKE/REV/TURN timing, retry back to BRAKE
        enter_fwd();
        check_eq("fwd_state", oState, 3'd1);
        check_eq("fwd_dirl", oDirL, 2'b10);
        check_eq("fwd_dirr", oDirR, 2'b10);
`ifndef SOFT_START_EN
        check_eq("fwd_duty", oDutyL, 8'd200);
`endif
        trigger_brake();
        measure("brake_len", 3'd2, 100, -1, 16'd0);
        check_eq("rev_state", oState, 3'd3);
        check_eq("rev_dirl", oDirL, 2'b01);
        check_eq("rev_dirr", oDirR, 2'b01);
`ifndef SOFT_START_EN
        check_eq("rev_duty", oDutyR, 8'd200);
`endif
        measure("rev_len", 3'd3, 400, -1, 16'd0);
        check_eq("turn_state", oState, 3'd4);
        check_eq("turn_dirl", oDirL, 2'b10);
        check_eq("turn_dirr", oDirR, 2'b01);
        measure("turn_len", 3'd4, 300, -1, 16'd0);
        check_eq("retry_to_brake", oState, 3'd2);

        // ---- asynchronous reset in the middle of TURN
        measure("brake2_len", 3'd2, 100, -1, 16'd0);
        measure("rev2_len", 3'd3, 400, -1, 16'd0);
        step(50);
        check_eq("mid_turn", oState, 3'd4);
        iRST = 1'b1;
        #1;
        check_eq("async_state", oState, 3'd0);
        check_eq("async_dutyl", oDutyL, 8'd0);
        check_eq("async_dirl", oDirL, 2'b00);
        check_eq("async_dirr", oDirR, 2'b00);
        check_eq("async_obst", oObstacle, 1'b0);
        step(1);
        iRST = 1'b0;
        iEnable = 1'b0;
        step(2);
        check_eq("post_rst_state", oState, 3'd0);

        // ---- clear sample during TURN returns to FWD
        do_reset();
        enter_fwd();
        trigger_brake();
        measure("c_brake_len", 3'd2, 100, -1, 16'd0);
        measure("c_rev_len", 3'd3, 400, -1, 16'd0);
        measure("c_turn_len", 3'd4, 300, 10, 16'd45);
        check_eq("clear_to_fwd", oState, 3'd1);
        check_eq("clear_obst", oObstacle, 1'b0);
`ifndef SOFT_START_EN
        check_eq("clear_duty", oDutyL, 8'd200);
`endif
        // retry was cleared: a full new failed cycle goes to BRAKE, not FAULT
        trigger_brake();
        measure("c2_brake_len", 3'd2, 100, -1, 16'd0);
        measure("c2_rev_len", 3'd3, 400, -1, 16'd0);
        measure("c2_turn_len", 3'd4, 300, -1, 16'd0);
        check_eq("c2_back_brake", oState, 3'd2);

        // ---- persistent obstacle -> FAULT after three cycles
        do_reset();
        enter_fwd();
        sample(16'd10);
        sample(16'd10);
        sample(16'd10);
        step(1);
        check_eq("f_brake", oState, 3'd2);
        for (int i = 0; i < 3; i++) begin
            measure("f_brake_len", 3'd2, 100, -1, 16'd0);
            measure("f_rev_len", 3'd3, 400, -1, 16'd0);
            measure("f_turn_len", 3'd4, 300, -1, 16'd0);
        end
        check_eq("fault_state", oState, 3'd5);
        check_eq("fault_duty", oDutyL, 8'd0);
        check_eq("fault_dirl", oDirL, 2'b00);
        check_eq("fault_dirr", oDirR, 2'b00);
        step(500);
        check_eq("fault_holds", oState, 3'd5);
        iEnable = 1'b0;
        step(2);
        check_eq("fault_exit", oState, 3'd0);
        enter_fwd();
        check_eq("fault_rerun", oState, 3'd1);

        // ---- strobe timeout, live duty, hysteresis of the near count
        do_reset();
        iDuty = 8'd0;
        enter_fwd();
        check_eq("zero_duty", oDutyL, 8'd0);
        iDuty = 8'd77;
        step(1);
`ifndef SOFT_START_EN
        check_eq("live_duty", oDutyR, 8'd77);
`endif
        measure("timeout_len", 3'd1, 199, -1, 16'd0);
        check_eq("timeout_brake", oState, 3'd2);

        do_reset();
        enter_fwd();
        sample(16'd19);
        sample(16'd25);
        sample(16'd19);
        step(2);
        check_eq("no_trigger", oState, 3'd1);
        check_eq("no_obst", oObstacle, 1'b0);
        sample(16'd0);
        sample(16'd19);
        step(1);
        check_eq("zero_ignored", oState, 3'd1);
        sample(16'd19);
        step(1);
        check_eq("third_near_trig", oState, 3'd2);

        // ---- duty at FWD entry (ramped when soft start is built in)
        do_reset();
        iDuty = 8'd64;
        enter_fwd();
`ifdef SOFT_START_EN
        check_eq("ramp_0", oDutyL, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check_eq("ramp_step", oDutyL, 32'(8 * k));
        end
        step(3);
        check_eq("ramp_hold", oDutyR, 8'd64);
`else
        check_eq("entry_duty", oDutyL, 8'd64);
        step(3);
        check_eq("entry_hold", oDutyR, 8'd64);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
